// File: rtl/bpu_ctrl_pkg.sv
// Shared definitions for the branch prediction controller: the instruction
// address bus width, the fixed instruction stride, the controller state
// encoding and the layout of one in-flight prediction entry.
package bpu_ctrl_pkg;

    localparam int INST_ADDR_W = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    // Every instruction occupies one 32-bit word.
    localparam inst_addr_t INST_STRIDE = 32'd4;

    // Statistics counters stop at this value instead of wrapping.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } bpu_state_t;

    typedef struct packed {
        inst_addr_t pc;
        logic       taken;
        inst_addr_t target;
    } pred_entry_t;

    // Fall-through address of an instruction; wraps modulo 2^32.
    function automatic inst_addr_t next_seq_pc(input inst_addr_t pc);
        return pc + INST_STRIDE;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue. DEPTH entries, power of two, so the pointers
// wrap naturally. The head entry is presented combinationally because the
// controller compares it against the resolution in the same cycle, which is
// why the storage lives in registers rather than a block RAM.
// A push while full is accepted only together with a pop. flush empties the
// queue and wins over any push or pop in the same cycle.
module pred_fifo
    import bpu_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    output pred_entry_t head,
    output logic        empty,
    output logic        full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pred_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    // Per-entry storage write; payload needs no reset since count guards it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == AW'(gi))) begin
                mem[gi] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bpu_ctrl.sv
// Branch prediction controller. Queues front-end predictions, compares the
// oldest one against the execute-stage resolution and, on a mispredict,
// flushes the pipeline, redirects fetch and stalls the front end for the
// two recovery cycles (FLUSH then RECOVER).
// Optional feature macro: BPU_STATS_EN enables the saturating resolved and
// mispredict counters; without it both counter outputs are tied to zero.
module bpu_ctrl
    import bpu_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid_i,
    input  inst_addr_t  pred_pc_i,
    input  logic        pred_taken_i,
    input  inst_addr_t  pred_addr_i,
    output logic        pred_ready_o,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  inst_addr_t  res_addr_i,
    output logic        flush_o,
    output inst_addr_t  redirect_addr_o,
    output logic        hold_o,
    output logic        err_o,
    output logic [31:0] resolved_cnt_o,
    output logic [31:0] mispredict_cnt_o
);

    bpu_state_t  state_reg;
    logic        flush_reg;
    logic        hold_reg;
    logic        err_reg;
    inst_addr_t  redirect_reg;

    pred_entry_t head;
    pred_entry_t push_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic        in_idle;
    logic        push_accept;
    logic        res_accept;
    logic        mispredict;
    inst_addr_t  actual_pc;

    assign in_idle = (state_reg == ST_IDLE);

    // When full, a resolution in the same cycle frees the head slot, so the
    // front end may still push alongside it.
    assign pred_ready_o = in_idle && (!fifo_full || res_valid_i);
    assign push_accept  = pred_valid_i && pred_ready_o;
    assign res_accept   = res_valid_i && in_idle && !fifo_empty;

    assign mispredict = res_accept &&
                        ((res_taken_i != head.taken) ||
                         (res_taken_i && (res_addr_i != head.target)));
    assign actual_pc  = res_taken_i ? res_addr_i : next_seq_pc(head.pc);

    assign push_data = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_addr_i};

    // A mispredict discards the whole queue, including any same-cycle push.
    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (mispredict),
        .push      (push_accept && !mispredict),
        .push_data (push_data),
        .pop       (res_accept && !mispredict),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Recovery FSM with registered flush/hold/error/redirect outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            flush_reg    <= 1'b0;
            hold_reg     <= 1'b0;
            err_reg      <= 1'b0;
            redirect_reg <= '0;
        end else begin
            flush_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    err_reg <= res_valid_i && fifo_empty;
                    if (mispredict) begin
                        state_reg    <= ST_FLUSH;
                        flush_reg    <= 1'b1;
                        hold_reg     <= 1'b1;
                        redirect_reg <= actual_pc;
                    end
                end
                ST_FLUSH: begin
                    state_reg <= ST_RECOVER;
                    hold_reg  <= 1'b1;
                end
                ST_RECOVER: begin
                    state_reg <= ST_IDLE;
                    hold_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    hold_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign flush_o         = flush_reg;
    assign hold_o          = hold_reg;
    assign err_o           = err_reg;
    assign redirect_addr_o = redirect_reg;

`ifdef BPU_STATS_EN
    logic [31:0] resolved_cnt_reg;
    logic [31:0] mispredict_cnt_reg;

    // Saturating statistics: every accepted resolution and every mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_cnt_reg   <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            if (res_accept && (resolved_cnt_reg != CNT_MAX)) begin
                resolved_cnt_reg <= resolved_cnt_reg + 32'd1;
            end
            if (mispredict && (mispredict_cnt_reg != CNT_MAX)) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
            end
        end
    end

    assign resolved_cnt_o   = resolved_cnt_reg;
    assign mispredict_cnt_o = mispredict_cnt_reg;
`else
    assign resolved_cnt_o   = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bpu_ctrl.sv
// Testbench for bpu_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// queue-based behavioural model of the controller.
module tb_bpu_ctrl;

    localparam int DEPTH = 4;
`ifdef BPU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic        pred_taken_i = 1'b0;
    logic [31:0] pred_addr_i = '0;
    logic        pred_ready_o;
    logic        res_valid_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic [31:0] res_addr_i = '0;
    logic        flush_o;
    logic [31:0] redirect_addr_o;
    logic        hold_o;
    logic        err_o;
    logic [31:0] resolved_cnt_o;
    logic [31:0] mispredict_cnt_o;

    always #5 clk = ~clk;

    bpu_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid_i     (pred_valid_i),
        .pred_pc_i        (pred_pc_i),
        .pred_taken_i     (pred_taken_i),
        .pred_addr_i      (pred_addr_i),
        .pred_ready_o     (pred_ready_o),
        .res_valid_i      (res_valid_i),
        .res_taken_i      (res_taken_i),
        .res_addr_i       (res_addr_i),
        .flush_o          (flush_o),
        .redirect_addr_o  (redirect_addr_o),
        .hold_o           (hold_o),
        .err_o            (err_o),
        .resolved_cnt_o   (resolved_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    // Model state: in-flight queue, recovery cycles still to go (2 = flush
    // cycle, 1 = recover cycle), and the expected registered outputs.
    ent_t        q[$];
    int          left = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_redir = '0;
    logic [31:0] m_res = '0;
    logic [31:0] m_mis = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: compare registered outputs, drive inputs,
    // compare the ready handshake, then advance the model across the edge.
    task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                        input logic [31:0] pa, input logic rv, input logic rt,
                        input logic [31:0] ra, input logic r);
        logic        m_ready;
        logic        mis;
        logic [31:0] act_pc;
        logic        do_push;
        @(negedge clk);
        chk("flush_o", flush_o, 32'(left == 2));
        chk("hold_o", hold_o, 32'(left > 0));
        chk("err_o", err_o, 32'(m_err));
        chk("redirect_addr_o", redirect_addr_o, m_redir);
        chk("resolved_cnt_o", resolved_cnt_o, STATS ? m_res : 32'd0);
        chk("mispredict_cnt_o", mispredict_cnt_o, STATS ? m_mis : 32'd0);
        pred_valid_i = pv; pred_pc_i = pc; pred_taken_i = pt; pred_addr_i = pa;
        res_valid_i = rv; res_taken_i = rt; res_addr_i = ra; rst = r;
        #1;
        m_ready = (left == 0) && ((q.size() < DEPTH) || rv);
        chk("pred_ready_o", pred_ready_o, 32'(m_ready));
        vectors++;
        do_push = pv && m_ready;
        m_err = 1'b0;
        if (r) begin
            q.delete();
            left = 0; m_redir = '0; m_res = '0; m_mis = '0;
        end else if (left > 0) begin
            left--;
        end else begin
            if (rv && q.size() == 0) begin
                m_err = 1'b1;
            end else if (rv) begin
                mis = (rt != q[0].taken) || (rt && (ra != q[0].target));
                act_pc = rt ? ra : q[0].pc + 32'd4;
                if (m_res != 32'hFFFF_FFFF) m_res++;
                if (mis) begin
                    if (m_mis != 32'hFFFF_FFFF) m_mis++;
                    m_redir = act_pc;
                    left = 2;
                    q.delete();
                    do_push = 1'b0;
                end else begin
                    void'(q.pop_front());
                end
            end
            if (do_push) q.push_back('{pc, pt, pa});
        end
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] pa);
        step(1'b1, pc, pt, pa, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] ra);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, rt, ra, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        after_edge();
        chk("rst_flush", flush_o, 32'd0);
        chk("rst_hold", hold_o, 32'd0);
        chk("rst_err", err_o, 32'd0);
        chk("rst_redirect", redirect_addr_o, 32'd0);
        chk("rst_ready", pred_ready_o, 32'd1);
        idle();

        // Correct taken prediction
        push(32'h100, 1'b1, 32'h140);
        resolve(1'b1, 32'h140);
        after_edge();
        chk("hit_flush", flush_o, 32'd0);
        chk("hit_res_cnt", resolved_cnt_o, STATS ? 32'd1 : 32'd0);
        chk("hit_mis_cnt", mispredict_cnt_o, 32'd0);

        // Predicted not-taken, actually taken
        push(32'h200, 1'b0, 32'h180);
        resolve(1'b1, 32'h180);
        after_edge();
        chk("mis_flush", flush_o, 32'd1);
        chk("mis_redirect", redirect_addr_o, 32'h180);
        chk("mis_hold1", hold_o, 32'd1);
        idle();
        after_edge();
        chk("mis_flush_done", flush_o, 32'd0);
        chk("mis_hold2", hold_o, 32'd1);
        idle();
        after_edge();
        chk("mis_hold_end", hold_o, 32'd0);
        chk("mis_ready", pred_ready_o, 32'd1);
        chk("mis_cnt", mispredict_cnt_o, STATS ? 32'd1 : 32'd0);

        // Mispredict with younger entries queued behind the head
        push(32'h300, 1'b1, 32'h340);
        push(32'h400, 1'b0, 32'h0);
        push(32'h500, 1'b0, 32'h0);
        push(32'h600, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        after_edge();
        chk("clr_redirect", redirect_addr_o, 32'h304);
        idle();
        idle();
        after_edge();
        chk("clr_ready", pred_ready_o, 32'd1);
        resolve(1'b1, 32'h340);
        after_edge();
        chk("clr_empty_err", err_o, 32'd1);

        // Full queue, then push alongside a correct resolution
        push(32'h700, 1'b0, 32'h0);
        push(32'h704, 1'b0, 32'h0);
        push(32'h708, 1'b0, 32'h0);
        push(32'h70C, 1'b0, 32'h0);
        after_edge();
        chk("full_ready", pred_ready_o, 32'd0);
        step(1'b1, 32'h900, 1'b1, 32'h940, 1'b1, 1'b0, 32'h0, 1'b0);
        resolve(1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        resolve(1'b1, 32'h940);
        after_edge();
        chk("full_kept_flush", flush_o, 32'd0);
        chk("full_kept_err", err_o, 32'd0);
        resolve(1'b0, 32'h0);
        after_edge();
        chk("full_drained_err", err_o, 32'd1);
        chk("err_no_hold", hold_o, 32'd0);
        idle();
        after_edge();
        chk("err_single_pulse", err_o, 32'd0);

        // Fall-through wraps at the top of the address space
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(1'b0, 32'h0);
        after_edge();
        chk("wrap_flush", flush_o, 32'd1);
        chk("wrap_redirect", redirect_addr_o, 32'h0);
        idle();
        idle();

        // Reset during FLUSH aborts recovery
        push(32'hA00, 1'b0, 32'h0);
        resolve(1'b1, 32'hB00);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        after_edge();
        chk("rstf_flush", flush_o, 32'd0);
        chk("rstf_hold", hold_o, 32'd0);
        chk("rstf_res_cnt", resolved_cnt_o, 32'd0);
        chk("rstf_mis_cnt", mispredict_cnt_o, 32'd0);
        idle();
        resolve(1'b0, 32'h0);
        after_edge();
        chk("rstf_empty_err", err_o, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic        pv;
            logic        pt;
            logic        rv;
            logic        rt;
            logic        r;
            logic [31:0] pc;
            logic [31:0] pa;
            logic [31:0] ra;
            pv = ($urandom_range(0, 9) < 6);
            pc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
            pt = 1'($urandom_range(0, 1));
            pa = $urandom() & 32'hFFFF_FFFC;
            rv = ($urandom_range(0, 9) < 4);
            r  = ($urandom_range(0, 199) == 0);
            if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
                rt = q[0].taken;
                ra = q[0].taken ? q[0].target : $urandom();
            end else begin
                rt = 1'($urandom_range(0, 1));
                ra = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].target : $urandom();
            end
            step(pv, pc, pt, pa, rv, rt, ra, r);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bpu_ctrl.md
BPU_CTRL -- requirements
Module: bpu_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, number of in-flight prediction entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pred_valid_i  input  1  front end issues a branch/jump prediction this cycle.
REQ-005 pred_pc_i  input  32  PC of the predicted instruction.
REQ-006 pred_taken_i  input  1  prediction-unit taken decision.
REQ-007 pred_addr_i  input  32  prediction-unit target address (pc + imm).
REQ-008 pred_ready_o  output  1  queue can accept a prediction.
REQ-009 res_valid_i  input  1  execute stage resolves the oldest in-flight branch.
REQ-010 res_taken_i  input  1  actual taken outcome.
REQ-011 res_addr_i  input  32  actual target address when taken.
REQ-012 flush_o  output  1  one-cycle pipeline flush pulse.
REQ-013 redirect_addr_o  output  32  correct fetch address, valid with flush_o.
REQ-014 hold_o  output  1  front end stall during recovery.
REQ-015 err_o  output  1  one-cycle pulse: resolution arrived with empty queue.
REQ-016 resolved_cnt_o, mispredict_cnt_o  output  32 each  statistics counters.

Function
REQ-017 Queue: FIFO of DEPTH entries {pc, taken, target}; push when pred_valid_i && pred_ready_o; pred_ready_o = !full && state==IDLE.
REQ-018 Pop head on every res_valid_i with queue non-empty; push and pop in the same cycle both take effect, count unchanged, allowed when full.
REQ-019 Expected next PC of entry = taken ? target : pc+4 (32-bit, wraps modulo 2^32); actual = res_taken_i ? res_addr_i : head.pc+4.
REQ-020 Mispredict = res_taken_i != head.taken, or both taken and res_addr_i != head.target.
REQ-021 States: IDLE, FLUSH, RECOVER. IDLE->FLUSH on mispredict; FLUSH->RECOVER unconditionally; RECOVER->IDLE unconditionally.
REQ-022 In FLUSH: flush_o=1, redirect_addr_o=actual next PC registered at the mispredict cycle; latency exactly 1 cycle after res_valid_i.
REQ-023 On mispredict the whole queue is cleared (head popped, younger entries discarded); a push in the same cycle is discarded.
REQ-024 In FLUSH and RECOVER: hold_o=1, pred_ready_o=0, res_valid_i ignored (no pop, no count).
REQ-025 res_valid_i with empty queue in IDLE: no state change, err_o=1 next cycle for one cycle.
REQ-026 redirect_addr_o holds last value outside FLUSH; flush_o, hold_o, err_o are registered outputs.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, queue empty, flush_o=0, hold_o=0, err_o=0, redirect_addr_o=0, counters=0, pred_ready_o=1 in the following cycle.
REQ-028 Reset mid-FLUSH/RECOVER aborts recovery; no flush pulse after reset.

Configuration
REQ-029 Macro BPU_STATS_EN: defined -> resolved_cnt_o increments per accepted resolution, mispredict_cnt_o per mispredict, both saturate at 32'hFFFF_FFFF; undefined -> counter logic absent, both outputs tied 0.

Structure
REQ-030 InstAddrBus width, state encodings and the +4 instruction stride belong in the shared defines package.
REQ-031 Queue implemented as sub-module pred_fifo (parameter DEPTH, flush input clearing pointers); controller FSM and compare in bpu_ctrl.

Verification
REQ-032 Push {pc=0x100,taken=1,target=0x140}; resolve taken=1 addr=0x140 -> no flush, resolved_cnt=1, mispredict_cnt=0.
REQ-033 Push {0x200,taken=0,target=0x180}; resolve taken=1 addr=0x180 -> flush_o next cycle, redirect_addr_o=0x180, hold_o for 2 cycles.
REQ-034 Push {0x300,taken=1,0x340} plus 3 younger entries; resolve taken=0 -> redirect_addr_o=0x304, queue empty afterwards, pred_ready_o=1 after RECOVER.
REQ-035 Fill 4 entries -> pred_ready_o=0; same-cycle push and correct resolve -> count stays 4, new entry retained.
REQ-036 res_valid_i with empty queue -> err_o single pulse, state IDLE; pc=0xFFFF_FFFC not-taken mispredict -> redirect_addr_o=0x0000_0000.
REQ-037 Assert rst during FLUSH -> next cycle flush_o=0, hold_o=0, counters 0, queue empty.
